instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Front-end stage directly upstream of the decoder/dispatch stage.
- Holds the PC and a direct-mapped word instruction cache, and fetches misses from the memory controller.
- Predicts branches with a 2-bit BHT and presents one instruction per cycle to the decoder: word, taken flag, and recovery PC.
- Redirects on ROB mispredict clear.

Parameters:
- ICACHE_IDX_W, 6: index bits; 2^6 = 64 one-word lines.
- BHT_IDX_W, 8: BHT index bits; 256 2-bit counters.
- RESET_PC, 32'h0: PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state holds.
- Decoder_not_ready_accept  in  1  decoder stall (ROB or LSB full).
- update_instr_valid  out  1  instruction word presented this cycle.
- update_instr  out  32  instruction word.
- update_instr_isjump  out  1  1 = predicted taken (next PC = pc+imm); 0 = next PC = pc+4.
- update_instr_jump_wrong_to_pc  out  32  PC to resume at if the prediction is wrong.
- ROB_clear  in  1  mispredict flush.
- ROB_clear_pc  in  32  correct PC after flush.
- ROB_br_commit  in  1  conditional branch committed.
- ROB_br_pc  in  32  PC of the committed branch.
- ROB_br_taken  in  1  actual outcome of the committed branch.
- IF_mem_req  out  1  fetch request, held high until mem_IF_valid.
- IF_mem_addr  out  32  word-aligned fetch address.
- mem_IF_valid  in  1  one-cycle response strobe.
- mem_IF_data  in  32  fetched word.

Behaviour:
- Reset (rst=0, async) clears:
  - pc=RESET_PC; all cache valid bits=0; BHT counters=2'b01 (weakly not-taken).
  - state=FETCH; every output=0.
- States:
  - FETCH: lookup pc in the cache.
    - Hit and output slot free (or being consumed this cycle): load the output register and advance pc to the predicted next PC. Throughput 1 per cycle on hits.
    - Miss: assert IF_mem_req with IF_mem_addr=pc, go to MISS.
  - MISS: hold the request. On mem_IF_valid, write the line (valid, tag=pc[31:ICACHE_IDX_W+2], data) and return to FETCH. The instruction issues on the next cycle as a hit.
  - DRAIN: entered when ROB_clear arrives during MISS. Keep IF_mem_req high until mem_IF_valid, still fill the cache, then go to FETCH at the latched clear PC. Never abandon a memory transaction.
- Output handshake:
  - The output register is consumed at a posedge with update_instr_valid=1, Decoder_not_ready_accept=0, rdy=1.
  - While the stall is high, all outputs hold stable and pc does not advance.
- Prediction is computed from the fetched word. imm uses the RISC-V B/J encodings, sign-extended; all arithmetic is 32-bit wrap.
  - JAL: isjump=1, next=pc+imm_J, wrong_to_pc=pc+4.
  - BRANCH (op 1100011): taken iff BHT[pc[BHT_IDX_W+1:2]][1]. If taken, next=pc+imm_B and wrong=pc+4. If not taken, next=pc+4 and wrong=pc+imm_B.
  - JALR and all other opcodes: isjump=0, next=pc+4, wrong_to_pc=pc+4 (ROB recovers JALR).
- BHT update on ROB_br_commit: saturating +1 if taken, -1 if not taken, at index ROB_br_pc[BHT_IDX_W+1:2]. The update lands the same cycle as any lookup; the lookup sees the old value.
- ROB_clear has highest priority, including over a simultaneous consume or stall:
  - Next cycle: update_instr_valid=0 and pc=ROB_clear_pc (via DRAIN if in MISS).
  - Cache and BHT are retained.
- rdy=0 freezes all state, including DRAIN, but not the async reset.

Optional Feature:
- Macro IF_BHT_EN.
- Defined: the BHT predictor described above.
- Undefined: no BHT storage; conditional branches are always predicted not-taken (isjump=0, wrong_to_pc=pc+imm_B); ROB_br_* inputs are ignored. JAL handling is unchanged.

Decomposition:
- Extend the shared op-map package with constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111.
- Add to the same package: immediate-extraction functions imm_B and imm_J, and the fetch state encoding (FETCH, MISS, DRAIN).
- One sub-module: icache_dm (tag/valid/data arrays, combinational hit lookup, single-port fill).

Test Plan:
1. Reset, then fetch at 0: addr 0 word 32'h00100093 (addi) → miss, IF_mem_req with addr 0. After response, one cycle later valid=1, instr=32'h00100093, isjump=0, wrong_to_pc=4.
2. pc=0x10 holding JAL +8 (32'h0080006F), cached → isjump=1, wrong_to_pc=0x14, next fetch address 0x18.
3. Branch at 0x20 with offset -16. Two commits of taken at 0x20, then fetch → isjump=1, next pc=0x10, wrong_to_pc=0x24. With IF_BHT_EN undefined → isjump=0, wrong_to_pc=0x10.
4. Decoder_not_ready_accept high for 3 cycles with valid output → outputs unchanged for 3 cycles; next instruction appears only after the stall drops.
5. ROB_clear with ROB_clear_pc=0x100 during MISS of 0x40 → request held until mem_IF_valid, line 0x40 filled, then fetch of 0x100. No valid output in between.
6. ROB_clear coincident with consume, stall and a BHT commit → valid=0 next cycle, pc=0x100, BHT counter still updated.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared op-map, immediate helpers, fetch FSM encoding and decoder payload for instr_fetch.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Payload presented to decode alongside the valid bit.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            isjump;
        logic [XLEN-1:0] wrong_pc;
    } fetch_out_t;

    // B-type immediate, sign-extended.
    function automatic logic [XLEN-1:0] imm_B(input logic [XLEN-1:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended.
    function automatic logic [XLEN-1:0] imm_J(input logic [XLEN-1:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Saturating 2-bit counter step toward the committed outcome.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, single-port fill.
module icache_dm
    import instr_fetch_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [29:0]      lookup_word,
    output logic             hit_c,
    output logic [XLEN-1:0]  data_c,
    input  logic             fill_en,
    input  logic [29:0]      fill_word,
    input  logic [XLEN-1:0]  fill_data
);

    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] fl_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] fl_tag;

    assign lk_idx = lookup_word[IDX_W-1:0];
    assign lk_tag = lookup_word[29:IDX_W];
    assign fl_idx = fill_word[IDX_W-1:0];
    assign fl_tag = fill_word[29:IDX_W];

    // Valid bits are the only cache state cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fl_idx] <= 1'b1;
        end
    end

    // Tag and data arrays written on fill.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fl_idx]  <= fl_tag;
            data_q[fl_idx] <= fill_data;
        end
    end

    assign hit_c  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign data_c = data_q[lk_idx];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, I-cache, miss handling and branch prediction feeding decode.
// Optional macro IF_BHT_EN enables the 2-bit BHT; without it branches predict not-taken.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ICACHE_IDX_W = 6,
    parameter int unsigned BHT_IDX_W    = 8,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        Decoder_not_ready_accept,
    output logic        update_instr_valid,
    output logic [31:0] update_instr,
    output logic        update_instr_isjump,
    output logic [31:0] update_instr_jump_wrong_to_pc,
    input  logic        ROB_clear,
    input  logic [31:0] ROB_clear_pc,
    input  logic        ROB_br_commit,
    input  logic [31:0] ROB_br_pc,
    input  logic        ROB_br_taken,
    output logic        IF_mem_req,
    output logic [31:0] IF_mem_addr,
    input  logic        mem_IF_valid,
    input  logic [31:0] mem_IF_data
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic         out_valid, out_valid_nxt;
    fetch_out_t   out_q, out_nxt;
    logic         req_q, req_nxt;
    logic [31:0]  addr_q, addr_nxt;

    logic         hit_c;
    logic [31:0]  word_c;
    logic         fill_en_c;
    logic         bht_taken_c;
    fetch_out_t   pred_c;
    logic [31:0]  pred_next_pc_c;
    logic         consume_c;
    logic         slot_free_c;

    icache_dm #(.IDX_W(ICACHE_IDX_W)) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_word (pc[31:2]),
        .hit_c       (hit_c),
        .data_c      (word_c),
        .fill_en     (fill_en_c),
        .fill_word   (addr_q[31:2]),
        .fill_data   (mem_IF_data)
    );

`ifdef IF_BHT_EN
    localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

    logic [1:0] bht_q [BHT_DEPTH];
    logic       unused_br_pc;

    assign unused_br_pc = ^{ROB_br_pc[31:BHT_IDX_W+2], ROB_br_pc[1:0]};

    // Counter training from ROB commits; a same-cycle lookup sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy && ROB_br_commit) begin
            bht_q[ROB_br_pc[BHT_IDX_W+1:2]] <= bht_next(bht_q[ROB_br_pc[BHT_IDX_W+1:2]], ROB_br_taken);
        end
    end

    assign bht_taken_c = bht_q[pc[BHT_IDX_W+1:2]][1];
`else
    logic unused_br;

    assign unused_br   = ^{ROB_br_commit, ROB_br_taken, ROB_br_pc, ROB_br_pc[BHT_IDX_W+1:2]};
    assign bht_taken_c = 1'b0;
`endif

    // Predicted next PC and recovery PC from the word at pc.
    always_comb begin
        pred_c.instr    = word_c;
        pred_c.isjump   = 1'b0;
        pred_c.wrong_pc = pc + 32'd4;
        pred_next_pc_c  = pc + 32'd4;
        case (word_c[6:0])
            OPC_JAL: begin
                pred_c.isjump  = 1'b1;
                pred_next_pc_c = pc + imm_J(word_c);
            end
            OPC_BRANCH: begin
                if (bht_taken_c) begin
                    pred_c.isjump  = 1'b1;
                    pred_next_pc_c = pc + imm_B(word_c);
                end else begin
                    pred_c.wrong_pc = pc + imm_B(word_c);
                end
            end
            OPC_JALR: ;
            default:  ;
        endcase
    end

    assign consume_c   = out_valid && !Decoder_not_ready_accept;
    assign slot_free_c = !out_valid || !Decoder_not_ready_accept;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // FSM next state; a flush during an outstanding miss drains it first.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (!ROB_clear && !hit_c) state_nxt = MISS;
            MISS: begin
                if (mem_IF_valid)   state_nxt = FETCH;
                else if (ROB_clear) state_nxt = DRAIN;
            end
            DRAIN:   if (mem_IF_valid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Next values for pc, decoder slot, memory request and cache fill.
    always_comb begin
        pc_nxt        = pc;
        out_valid_nxt = out_valid && !consume_c;
        out_nxt       = out_q;
        req_nxt       = req_q;
        addr_nxt      = addr_q;
        fill_en_c     = 1'b0;
        case (state)
            FETCH: begin
                if (!ROB_clear) begin
                    if (hit_c) begin
                        if (slot_free_c) begin
                            out_valid_nxt = 1'b1;
                            out_nxt       = pred_c;
                            pc_nxt        = pred_next_pc_c;
                        end
                    end else begin
                        req_nxt  = 1'b1;
                        addr_nxt = {pc[31:2], 2'b00};
                    end
                end
            end
            MISS, DRAIN: begin
                if (mem_IF_valid) begin
                    fill_en_c = rdy;
                    req_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
        if (ROB_clear) begin
            out_valid_nxt = 1'b0;
            pc_nxt        = ROB_clear_pc;
        end
    end

    // Datapath registers, frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else if (rdy) begin
            pc        <= pc_nxt;
            out_valid <= out_valid_nxt;
            out_q     <= out_nxt;
            req_q     <= req_nxt;
            addr_q    <= addr_nxt;
        end
    end

    assign update_instr_valid            = out_valid;
    assign update_instr                  = out_q.instr;
    assign update_instr_isjump           = out_q.isjump;
    assign update_instr_jump_wrong_to_pc = out_q.wrong_pc;
    assign IF_mem_req                    = req_q;
    assign IF_mem_addr                   = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expectations follow the IF_BHT_EN setting of the build.
module tb_instr_fetch;

    localparam logic [31:0] ADDI1 = 32'h00100093;
    localparam logic [31:0] ADDI2 = 32'h00200113;
    localparam logic [31:0] ADDI3 = 32'h00300193;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] JAL8  = 32'h0080006F;
    localparam logic [31:0] BRM16 = 32'hFE0008E3;
    localparam logic [31:0] W40   = 32'h00400213;
    localparam logic [31:0] ADDI5 = 32'h00500293;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        Decoder_not_ready_accept = 1'b1;
    logic        update_instr_valid;
    logic [31:0] update_instr;
    logic        update_instr_isjump;
    logic [31:0] update_instr_jump_wrong_to_pc;
    logic        ROB_clear = 1'b0;
    logic [31:0] ROB_clear_pc = '0;
    logic        ROB_br_commit = 1'b0;
    logic [31:0] ROB_br_pc = '0;
    logic        ROB_br_taken = 1'b0;
    logic        IF_mem_req;
    logic [31:0] IF_mem_addr;
    logic        mem_IF_valid = 1'b0;
    logic [31:0] mem_IF_data = '0;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk                           (clk),
        .rst                           (rst),
        .rdy                           (rdy),
        .Decoder_not_ready_accept      (Decoder_not_ready_accept),
        .update_instr_valid            (update_instr_valid),
        .update_instr                  (update_instr),
        .update_instr_isjump           (update_instr_isjump),
        .update_instr_jump_wrong_to_pc (update_instr_jump_wrong_to_pc),
        .ROB_clear                     (ROB_clear),
        .ROB_clear_pc                  (ROB_clear_pc),
        .ROB_br_commit                 (ROB_br_commit),
        .ROB_br_pc                     (ROB_br_pc),
        .ROB_br_taken                  (ROB_br_taken),
        .IF_mem_req                    (IF_mem_req),
        .IF_mem_addr                   (IF_mem_addr),
        .mem_IF_valid                  (mem_IF_valid),
        .mem_IF_data                   (mem_IF_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] a, input string tag);
        int n;
        n = 0;
        while (IF_mem_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, ".req"}, 32'(IF_mem_req), 32'd1);
        chk({tag, ".addr"}, IF_mem_addr, a);
    endtask

    task automatic respond(input logic [31:0] d);
        mem_IF_data  = d;
        mem_IF_valid = 1'b1;
        step();
        mem_IF_valid = 1'b0;
        mem_IF_data  = '0;
    endtask

    task automatic expect_out(input logic [31:0] d, input logic j, input logic [31:0] w, input string tag);
        int n;
        n = 0;
        while (update_instr_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, ".valid"}, 32'(update_instr_valid), 32'd1);
        chk({tag, ".instr"}, update_instr, d);
        chk({tag, ".isjump"}, 32'(update_instr_isjump), 32'(j));
        chk({tag, ".wrong"}, update_instr_jump_wrong_to_pc, w);
    endtask

    task automatic consume();
        Decoder_not_ready_accept = 1'b0;
        step();
        Decoder_not_ready_accept = 1'b1;
    endtask

    task automatic fetch_line(input logic [31:0] a, input logic [31:0] d, input logic j,
                              input logic [31:0] w, input string tag);
        wait_req(a, tag);
        respond(d);
        expect_out(d, j, w, tag);
        consume();
    endtask

    task automatic clear_to(input logic [31:0] p);
        ROB_clear    = 1'b1;
        ROB_clear_pc = p;
        step();
        ROB_clear    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst.valid", 32'(update_instr_valid), 32'd0);
        chk("rst.instr", update_instr, 32'd0);
        chk("rst.isjump", 32'(update_instr_isjump), 32'd0);
        chk("rst.wrong", update_instr_jump_wrong_to_pc, 32'd0);
        chk("rst.req", 32'(IF_mem_req), 32'd0);
        chk("rst.addr", IF_mem_addr, 32'd0);

        // Release reset while training the branch at 0x20 as taken twice.
        rst           = 1'b1;
        ROB_br_commit = 1'b1;
        ROB_br_pc     = 32'h20;
        ROB_br_taken  = 1'b1;
        step();
        step();
        ROB_br_commit = 1'b0;

        // Cold miss at 0, then issue one cycle after the fill.
        wait_req(32'h0, "t1");
        chk("t1.nvalid", 32'(update_instr_valid), 32'd0);
        respond(ADDI1);
        chk("t1.req_drop", 32'(IF_mem_req), 32'd0);
        chk("t1.fill_cycle", 32'(update_instr_valid), 32'd0);
        step();
        chk("t1.valid", 32'(update_instr_valid), 32'd1);
        chk("t1.instr", update_instr, ADDI1);
        chk("t1.isjump", 32'(update_instr_isjump), 32'd0);
        chk("t1.wrong", update_instr_jump_wrong_to_pc, 32'h4);
        consume();

        fetch_line(32'h04, ADDI2, 1'b0, 32'h08, "seq4");
        fetch_line(32'h08, NOP,   1'b0, 32'h0C, "seq8");
        fetch_line(32'h0C, NOP,   1'b0, 32'h10, "seqC");
        fetch_line(32'h10, JAL8,  1'b1, 32'h14, "t2.jal");
        fetch_line(32'h18, ADDI3, 1'b0, 32'h1C, "t2.target");
        fetch_line(32'h1C, NOP,   1'b0, 32'h20, "seq1C");

        // Backward branch at 0x20.
        wait_req(32'h20, "t3");
        respond(BRM16);
`ifdef IF_BHT_EN
        expect_out(BRM16, 1'b1, 32'h24, "t3.br");
`else
        expect_out(BRM16, 1'b0, 32'h10, "t3.br");
`endif

        // Three stalled cycles hold the branch in place.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4.valid", 32'(update_instr_valid), 32'd1);
            chk("t4.instr", update_instr, BRM16);
`ifdef IF_BHT_EN
            chk("t4.isjump", 32'(update_instr_isjump), 32'd1);
            chk("t4.wrong", update_instr_jump_wrong_to_pc, 32'h24);
`else
            chk("t4.isjump", 32'(update_instr_isjump), 32'd0);
            chk("t4.wrong", update_instr_jump_wrong_to_pc, 32'h10);
`endif
        end
        consume();
`ifdef IF_BHT_EN
        // Predicted target 0x10 is cached and loads as the branch is consumed.
        chk("t4.next_valid", 32'(update_instr_valid), 32'd1);
        chk("t4.next_instr", update_instr, JAL8);
        chk("t4.next_wrong", update_instr_jump_wrong_to_pc, 32'h14);
        clear_to(32'h40);
        chk("t5a.valid", 32'(update_instr_valid), 32'd0);
`else
        chk("t4.next_valid", 32'(update_instr_valid), 32'd0);
        chk("t4.next_req", 32'(IF_mem_req), 32'd1);
        chk("t4.next_addr", IF_mem_addr, 32'h24);
        // Flush during the 0x24 miss drains it before moving on.
        clear_to(32'h40);
        chk("t5a.valid", 32'(update_instr_valid), 32'd0);
        chk("t5a.req", 32'(IF_mem_req), 32'd1);
        chk("t5a.addr", IF_mem_addr, 32'h24);
        respond(NOP);
        chk("t5a.drained_valid", 32'(update_instr_valid), 32'd0);
`endif

        // Flush to 0x100 during the 0x40 miss.
        wait_req(32'h40, "t5");
        clear_to(32'h100);
        chk("t5.hold_req", 32'(IF_mem_req), 32'd1);
        chk("t5.hold_addr", IF_mem_addr, 32'h40);
        chk("t5.hold_valid", 32'(update_instr_valid), 32'd0);
        step();
        chk("t5.hold2_req", 32'(IF_mem_req), 32'd1);
        chk("t5.hold2_addr", IF_mem_addr, 32'h40);
        respond(W40);
        chk("t5.post_valid", 32'(update_instr_valid), 32'd0);
        wait_req(32'h100, "t5.new");
        chk("t5.new_valid", 32'(update_instr_valid), 32'd0);
        respond(ADDI5);
        expect_out(ADDI5, 1'b0, 32'h104, "t5.out");

        // Flush under stall with a not-taken commit; 0x40 must hit from the drained fill.
        ROB_clear     = 1'b1;
        ROB_clear_pc  = 32'h40;
        ROB_br_commit = 1'b1;
        ROB_br_pc     = 32'h20;
        ROB_br_taken  = 1'b0;
        step();
        ROB_clear     = 1'b0;
        ROB_br_commit = 1'b0;
        chk("t6a.flush_valid", 32'(update_instr_valid), 32'd0);
        step();
        chk("t6a.valid", 32'(update_instr_valid), 32'd1);
        chk("t6a.instr", update_instr, W40);
        chk("t6a.wrong", update_instr_jump_wrong_to_pc, 32'h44);
        chk("t6a.req", 32'(IF_mem_req), 32'd0);

        // Flush over a consume with another not-taken commit; counter falls to weakly not-taken.
        ROB_clear                = 1'b1;
        ROB_clear_pc             = 32'h20;
        Decoder_not_ready_accept = 1'b0;
        ROB_br_commit            = 1'b1;
        step();
        ROB_clear                = 1'b0;
        Decoder_not_ready_accept = 1'b1;
        ROB_br_commit            = 1'b0;
        chk("t6b.flush_valid", 32'(update_instr_valid), 32'd0);
        step();
        chk("t6b.valid", 32'(update_instr_valid), 32'd1);
        chk("t6b.instr", update_instr, BRM16);
        chk("t6b.isjump", 32'(update_instr_isjump), 32'd0);
        chk("t6b.wrong", update_instr_jump_wrong_to_pc, 32'h10);
        chk("t6b.req", 32'(IF_mem_req), 32'd0);

        // rdy low blocks the consume and freezes everything.
        rdy                      = 1'b0;
        Decoder_not_ready_accept = 1'b0;
        step();
        step();
        chk("t7.valid", 32'(update_instr_valid), 32'd1);
        chk("t7.instr", update_instr, BRM16);
        chk("t7.req", 32'(IF_mem_req), 32'd0);
        rdy                      = 1'b1;
        Decoder_not_ready_accept = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
